// File: rtl/uart_stim_tx_pkg.sv
// rtl/uart_stim_tx_pkg.sv - shared constants and FSM encoding for the UART stimulus transmitter
package uart_stim_tx_pkg;

    localparam int UART_DATA_BITS = 8;

    // Baud period shared with the decoder: 100 MHz / 115200
    localparam int UART_DEFAULT_CLK_DIV = 868;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_stim_tx_if.sv
// rtl/uart_stim_tx_if.sv - byte handshake and line/status signals of the UART stimulus transmitter
interface uart_stim_tx_if #(
    parameter int FIFO_AW = 4
) ();
    logic [7:0]       data_i;
    logic             valid_i;
    logic             ready_o;
    logic             tx_o;
    logic             busy_o;
    logic [FIFO_AW:0] level_o;

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  tx_o,
        input  busy_o,
        input  level_o
    );

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output tx_o,
        output busy_o,
        output level_o
    );
endinterface

// File: rtl/uart_stim_tx_fifo.sv
// rtl/uart_stim_tx_fifo.sv - synchronous byte FIFO with occupancy count
module uart_stim_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [7:0]       i_data,
    input  logic             i_pop,
    output logic [7:0]       o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [FIFO_AW:0] o_level
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_level == (FIFO_AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rd_ptr];

    // Never write into a full FIFO nor read from an empty one
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage array; contents need no reset because level guards every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the level unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/uart_stim_tx.sv
// rtl/uart_stim_tx.sv - FIFO-buffered 8N1 UART transmitter; UART_STIM_TX_PARITY_EN adds an even parity bit
module uart_stim_tx
    import uart_stim_tx_pkg::*;
#(
    parameter int CLK_DIV = UART_DEFAULT_CLK_DIV,
    parameter int FIFO_AW = 4
) (
    input  logic           clk,
    input  logic           rst,
    uart_stim_tx_if.slave  bus
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_e        r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [7:0]       r_shreg, w_shreg_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic             r_tx, w_tx_nxt;
    logic             r_busy, w_busy_nxt;
`ifdef UART_STIM_TX_PARITY_EN
    logic             r_par, w_par_nxt;
`endif

    logic             w_push, w_pop, w_full, w_empty, w_bit_end;
    logic [7:0]       w_head;
    logic [FIFO_AW:0] w_level, w_level_nxt;

    uart_stim_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (bus.data_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign bus.ready_o = ~w_full;
    assign bus.tx_o    = r_tx;
    assign bus.busy_o  = r_busy;
    assign bus.level_o = w_level;

    assign w_push      = bus.valid_i & ~w_full;
    assign w_bit_end   = (r_cnt == '0);
    assign w_level_nxt = w_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);

    // Next-state logic: bit timing, FIFO pops and the registered line/busy values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_idx;
        w_pop       = 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
        w_par_nxt   = r_par;
`endif
        if (r_state != ST_IDLE) begin
            w_cnt_nxt = w_bit_end ? BIT_LAST : r_cnt - 1'b1;
        end
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = w_head;
                    w_cnt_nxt   = BIT_LAST;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_START;
`ifdef UART_STIM_TX_PARITY_EN
                    w_par_nxt   = even_parity(w_head);
`endif
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shreg_nxt = r_shreg >> 1;
                    w_idx_nxt   = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
`ifdef UART_STIM_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_STIM_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) w_state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_empty) begin
                        // Chain straight into the next start bit, no idle gap
                        w_pop       = 1'b1;
                        w_shreg_nxt = w_head;
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_START;
`ifdef UART_STIM_TX_PARITY_EN
                        w_par_nxt   = even_parity(w_head);
`endif
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shreg_nxt[0];
`ifdef UART_STIM_TX_PARITY_EN
            ST_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:   w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE) | (w_level_nxt != '0);
    end

    // State register; reset abandons any frame in flight and idles the line high
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_idx   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_STIM_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_shreg_nxt;
            r_idx   <= w_idx_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
`ifdef UART_STIM_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

endmodule
